// File: rtl/sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Optional feature macro used by the top: SUB_OVERFLOW_EN (adds the overflow port).
package sub_pkg;

    // Controller states: waiting for operands, shifting bits, presenting the result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width; the counter only has to reach WIDTH-1
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: borrow counterpart of the ripple-adder full_adder cell.
// Computes a - b - bin, giving the difference bit d and the borrow out bout.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow equations of a single subtractor cell
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: A - B one bit per clock, LSB first, through a single
// full_subtractor cell with a registered borrow, behind valid/ready handshakes.
// Optional feature macro: SUB_OVERFLOW_EN adds a signed-overflow output.
module serial_ripple_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  diff_sh;
    logic              borrow;
    logic [CW-1:0]     count;
    logic              d;
    logic              bout;
    logic              accept;
    logic              last_bit;

`ifdef SUB_OVERFLOW_EN
    logic              a_sign;
    logic              b_sign;
`endif

    assign accept   = in_valid && in_ready;
    assign last_bit = (count == CW'(WIDTH - 1));

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    // State register; reset returns to IDLE and discards any in-flight operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept in IDLE, shift WIDTH bits in BUSY, hand off in DONE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = BUSY;
            BUSY:    if (last_bit) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake and result outputs decoded from the registered state only;
    // results are masked to zero outside DONE so they are only seen when valid
    always_comb begin
        in_ready   = (state == IDLE) && rst_n;
        out_valid  = (state == DONE);
        diff       = (state == DONE) ? diff_sh : '0;
        borrow_out = (state == DONE) ? borrow : 1'b0;
`ifdef SUB_OVERFLOW_EN
        overflow   = (state == DONE) && (a_sign != b_sign) && (diff_sh[WIDTH-1] != a_sign);
`endif
    end

    // Datapath: latch operands on accept, then shift one bit per cycle through the cell
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            borrow  <= 1'b0;
            count   <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                a_sh    <= A;
                b_sh    <= B;
                diff_sh <= '0;
                borrow  <= 1'b0;
                count   <= '0;
            end
        end else if (state == BUSY) begin
            diff_sh <= {d, diff_sh[WIDTH-1:1]};
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            borrow  <= bout;
            count   <= count + CW'(1);
        end
    end

`ifdef SUB_OVERFLOW_EN
    // Operand sign bits kept aside, since the shift registers lose them while shifting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sign <= 1'b0;
            b_sign <= 1'b0;
        end else if (accept) begin
            a_sign <= A[WIDTH-1];
            b_sign <= B[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Scoreboard testbench for serial_ripple_subtractor (WIDTH = 8).
// Define SUB_OVERFLOW_EN to also check the overflow output.
module tb_serial_ripple_subtractor;

    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borrow_out;
    logic       overflow;

    exp_t exp_q[$];
    int   check_count = 0;
    int   pass_count  = 0;

    serial_ripple_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SUB_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

`ifndef SUB_OVERFLOW_EN
    assign overflow = 1'b0;
`endif

    // Free-running clock
    always #5 clk = ~clk;

    // Global watchdog so the run can never hang
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model straight from the arithmetic definition
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t r;
        int   ua;
        int   ub;
        int   sa;
        int   sb;
        int   sd;
        ua   = int'(a);
        ub   = int'(b);
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        sd   = sa - sb;
        r.d  = 8'((ua - ub + 256) % 256);
        r.bo = (ua < ub);
        r.ov = (sd > 127) || (sd < -128);
        return r;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        check_count++;
        if (act == exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: whenever a result is being handed off, compare against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("diff", int'(diff), int'(e.d));
                checkOutput("borrow_out", int'(borrow_out), int'(e.bo));
`ifdef SUB_OVERFLOW_EN
                checkOutput("overflow", int'(overflow), int'(e.ov));
`endif
            end
        end
    end

    // Wait (bounded) for in_ready; caller is aligned just after a rising edge
    task automatic waitReady(output bit ok);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = in_ready;
        if (!ok) checkOutput("in_ready_timeout", 0, 1);
    endtask

    // Issue one operation, optionally holding out_ready low and poking in_valid while busy
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input int hold, input bit pulse_busy);
        bit   ok;
        exp_t e;
        waitReady(ok);
        if (!ok) return;
        e         = model(a, b);
        out_ready = (hold == 0);
        A         = a;
        B         = b;
        in_valid  = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A        = 8'($urandom);
        B        = 8'($urandom);
        checkOutput("in_ready_busy", int'(in_ready), 0);
        if (pulse_busy) begin
            fork
                begin
                    @(posedge clk);
                    #1;
                    in_valid = 1'b1;
                    A        = 8'd9;
                    B        = 8'd9;
                    @(posedge clk);
                    #1;
                    in_valid = 1'b0;
                end
            join_none
        end
        repeat (WIDTH - 1) @(posedge clk);
        @(negedge clk);
        checkOutput("out_valid_early", int'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("out_valid_latency", int'(out_valid), 1);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                if (i > 0) @(negedge clk);
                checkOutput("hold_out_valid", int'(out_valid), 1);
                checkOutput("hold_in_ready", int'(in_ready), 0);
                checkOutput("hold_diff", int'(diff), int'(e.d));
                @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput("idle_in_ready", int'(in_ready), 1);
        checkOutput("idle_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
    endtask

    // Reset in the middle of an operation: nothing must come out of it
    task automatic resetMidOp();
        bit ok;
        int seen;
        waitReady(ok);
        if (!ok) return;
        out_ready = 1'b1;
        A         = 8'd100;
        B         = 8'd50;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", int'(in_ready), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_diff", int'(diff), 0);
        checkOutput("rst_borrow", int'(borrow_out), 0);
        checkOutput("rst_overflow", int'(overflow), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_after_release", int'(in_ready), 1);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("no_valid_after_reset", seen, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", int'(in_ready), 0);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_diff", int'(diff), 0);
        checkOutput("reset_borrow", int'(borrow_out), 0);
        checkOutput("reset_overflow", int'(overflow), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_first_cycle", int'(in_ready), 1);
        @(posedge clk);
        #1;

        $display("[TB] directed operations");
        applyStimulus(8'd48, 8'd33, 0, 1'b0);
        applyStimulus(8'd0, 8'd1, 0, 1'b0);
        applyStimulus(8'd3, 8'd248, 0, 1'b0);
        applyStimulus(8'd128, 8'd1, 0, 1'b0);
        applyStimulus(8'd127, 8'd255, 0, 1'b0);
        applyStimulus(8'd245, 8'd3, 5, 1'b0);
        applyStimulus(8'd200, 8'd73, 0, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("busy_pulse_no_extra", exp_q.size(), 0);

        $display("[TB] reset during operation");
        resetMidOp();
        applyStimulus(8'd7, 8'd2, 0, 1'b0);

        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        repeat (4) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
